sprite_fb_writer: RTL
=====================

// Module: sprite_fb_writer
// PURPOSE
//  Writer end of the sprite pipeline. Accepts a command (start_x, start_y, width, height),
//  then a row-major 8-bit pixel stream with a valid/ready handshake, for example from the ROM sprite reader.
//  Writes each pixel into the byte-lane SRAM frame buffer at (start_x+col, start_y+row).
//  Sits between the sprite ROM reader and the external SRAM/tristate data bus.
// PARAMETERS
//  FB_W          640   frame buffer width in pixels
//  FB_H          480   frame buffer height in pixels
//  WRITE_CYCLES  2     cycles sram_we_n is held low per write (>=1)
//  KEY_COLOR     8'hE3 transparent colour index (used only with TRANSPARENCY_EN)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high
//  begin_write  in   1   start command; sampled only in IDLE
//  start_x      in   10  sprite origin column (latched on begin_write)
//  start_y      in   10  sprite origin row (latched)
//  width        in   10  sprite width in pixels (latched)
//  height       in   10  sprite height in pixels (latched)
//  pix_valid    in   1   pix_data valid
//  pix_data     in   8   pixel colour index
//  pix_ready    out  1   writer accepts pixel this cycle
//  sram_addr    out  20  SRAM word address = linear_index>>1
//  sram_wdata   out  16  {pix,pix}; the lane selects which byte lands
//  sram_ce_n    out  1   chip enable, active low
//  sram_oe_n    out  1   output enable, held 1 (never reads)
//  sram_we_n    out  1   write strobe, active low
//  sram_lb_n    out  1   low byte lane (linear_index[0]==0)
//  sram_ub_n    out  1   high byte lane (linear_index[0]==1)
//  busy         out  1   high in any state other than IDLE
//  done         out  1   one-cycle pulse when the sprite is finished
// BEHAVIOUR
//  Reset: state=IDLE; pix_ready=0, done=0, busy=0, sram_we_n=1, sram_ce_n=1, sram_oe_n=1,
//   sram_lb_n=1, sram_ub_n=1, sram_addr=0, sram_wdata=0, row=col=0. A reset mid-operation aborts
//   and deasserts we_n in the same edge.
//  FSM IDLE->ACCEPT->WRITE->ACCEPT...->DONE->IDLE.
//  IDLE: on begin_write, latch the command and go to ACCEPT; if width==0 or height==0, go to DONE.
//   begin_write in any other state is ignored.
//  ACCEPT: pix_ready=1 (registered). A handshake is pix_valid&pix_ready.
//   On handshake: latch the pixel and address, then go to WRITE, or skip (see clip/key).
//  WRITE: ce_n=0, we_n=0, lane strobe low, pix_ready=0, for exactly WRITE_CYCLES cycles.
//   addr, data and lane stay stable for the whole window. Afterwards advance the counters.
//  Counter advance: col+1; at col==width-1, col=0 and row+1. After the last pixel
//   (row==height-1, col==width-1) go to DONE, otherwise go to ACCEPT.
//  DONE: done=1 for one cycle, then IDLE. Throughput is 1 px per WRITE_CYCLES+1 clk.
//  Address: x=start_x+col, y=start_y+row, each 11 bits (no wrap).
//   linear_index = y*FB_W + x, 20 bits.
//  Clip: if x>=FB_W or y>=FB_H, the pixel is consumed with no SRAM write.
//   The FSM stays in ACCEPT and the counters advance in the same cycle.
//  Extra pixels after DONE are not accepted (pix_ready=0).
// CONFIGURATION
//  TRANSPARENCY_EN defined: a handshaked pixel ==KEY_COLOR is consumed and skipped like a
//   clipped pixel (no WRITE, no strobe).
//  TRANSPARENCY_EN undefined: every in-bounds pixel is written; KEY_COLOR is unused.
// STRUCTURE
//  Package vv_gfx_pkg: FB_W/FB_H constants, pixel_t (logic [7:0]), coord_t (logic [9:0]),
//   fbw_state_t enum {IDLE, ACCEPT, WRITE, DONE}.
//  Sub-module fb_addr_gen: combinational (x,y) -> {word_addr, lane, in_bounds}.
// TESTING
//  1) 2x2 sprite at (0,0), pixels 11,22,33,44, valid always high
//     -> writes addr0 lb, addr0 ub, addr320 lb, addr320 ub; done at the end.
//  2) 1x1 at (639,479), pixel 5A -> sram_addr=153599, ub_n=0, wdata=5A5A, we_n low 2 cycles, done.
//  3) 4x1 at (638,0) -> only x=638,639 are written; 4 handshakes, 2 strobes, done.
//  4) width=0 -> done pulses 2 cycles after begin_write; no pix_ready, no strobe.
//  5) reset asserted during WRITE -> next cycle we_n=1, busy=0, IDLE; the next command works normally.
//  6) TRANSPARENCY_EN, 3x1 pixels {E3,07,E3} -> a single write (07, x=1); done after 3 handshakes.

Source files
------------

// File: rtl/vv_gfx_pkg.sv
// vv_gfx_pkg: shared frame buffer geometry, pixel/coordinate types and writer FSM states
package vv_gfx_pkg;
    localparam int FB_W = 640;
    localparam int FB_H = 480;
    typedef logic [7:0] pixel_t;
    typedef logic [9:0] coord_t;
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} fbw_state_t;
endpackage

// File: rtl/sprite_fb_writer_if.sv
// sprite_fb_writer_if: command, pixel stream and SRAM bus of the sprite frame buffer writer
interface sprite_fb_writer_if;
    import vv_gfx_pkg::*;
    logic        begin_write;
    coord_t      start_x;
    coord_t      start_y;
    coord_t      width;
    coord_t      height;
    logic        pix_valid;
    pixel_t      pix_data;
    logic        pix_ready;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;
    logic        busy;
    logic        done;
    modport master (
        output begin_write, start_x, start_y, width, height, pix_valid, pix_data,
        input  pix_ready, sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n,
               sram_lb_n, sram_ub_n, busy, done
    );
    modport slave (
        input  begin_write, start_x, start_y, width, height, pix_valid, pix_data,
        output pix_ready, sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n,
               sram_lb_n, sram_ub_n, busy, done
    );
endinterface

// File: rtl/sprite_fb_writer_addr_gen.sv
// fb_addr_gen: maps a pixel position to SRAM word address, byte lane and on-screen flag
module fb_addr_gen
    import vv_gfx_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic [19:0] word_addr,
    output logic        lane,
    output logic        in_bounds
);
    logic [19:0] lin;
    assign lin       = 20'(y * FB_W) + 20'(x);
    assign word_addr = {1'b0, lin[19:1]};
    assign lane      = lin[0];
    assign in_bounds = (x < 11'(FB_W)) && (y < 11'(FB_H));
endmodule

// File: rtl/sprite_fb_writer.sv
// sprite_fb_writer: writes a row-major pixel stream into the byte-lane SRAM frame buffer; TRANSPARENCY_EN skips KEY_COLOR pixels
module sprite_fb_writer
    import vv_gfx_pkg::*;
#(
    parameter int WRITE_CYCLES = 2
`ifdef TRANSPARENCY_EN
    , parameter pixel_t KEY_COLOR = 8'hE3
`endif
) (
    input logic               clk,
    input logic               reset,
    sprite_fb_writer_if.slave bus
);
    localparam int CW = $clog2(WRITE_CYCLES) + 1;

    fbw_state_t  state;
    coord_t      sx, sy, w, h, row, col;
    logic [CW-1:0] cnt;
    logic [10:0] x, y;
    logic [19:0] word_addr;
    logic        lane, in_bounds, key_hit, last_col, last_px;

    assign x        = {1'b0, sx} + {1'b0, col};
    assign y        = {1'b0, sy} + {1'b0, row};
    assign last_col = col == w - 10'd1;
    assign last_px  = last_col && (row == h - 10'd1);

`ifdef TRANSPARENCY_EN
    assign key_hit = bus.pix_data == KEY_COLOR;
`else
    assign key_hit = 1'b0;
`endif

    fb_addr_gen u_addr (
        .x         (x),
        .y         (y),
        .word_addr (word_addr),
        .lane      (lane),
        .in_bounds (in_bounds)
    );

    assign bus.busy      = state != IDLE;
    assign bus.sram_oe_n = 1'b1;

    // Writer FSM: accept one pixel, strobe it for WRITE_CYCLES, advance row/col; skipped pixels advance in place
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.pix_ready  <= 1'b0;
            bus.done       <= 1'b0;
            bus.sram_we_n  <= 1'b1;
            bus.sram_ce_n  <= 1'b1;
            bus.sram_lb_n  <= 1'b1;
            bus.sram_ub_n  <= 1'b1;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            row            <= '0;
            col            <= '0;
            cnt            <= '0;
            sx             <= '0;
            sy             <= '0;
            w              <= '0;
            h              <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.begin_write) begin
                    sx  <= bus.start_x;
                    sy  <= bus.start_y;
                    w   <= bus.width;
                    h   <= bus.height;
                    row <= '0;
                    col <= '0;
                    if (bus.width == '0 || bus.height == '0) state <= DONE;
                    else begin
                        state         <= ACCEPT;
                        bus.pix_ready <= 1'b1;
                    end
                end
                ACCEPT: if (bus.pix_valid && bus.pix_ready) begin
                    if (in_bounds && !key_hit) begin
                        bus.sram_addr  <= word_addr;
                        bus.sram_wdata <= {bus.pix_data, bus.pix_data};
                        bus.sram_lb_n  <= lane;
                        bus.sram_ub_n  <= !lane;
                        bus.sram_ce_n  <= 1'b0;
                        bus.sram_we_n  <= 1'b0;
                        bus.pix_ready  <= 1'b0;
                        cnt            <= '0;
                        state          <= WRITE;
                    end else begin
                        col <= last_col ? '0 : col + 10'd1;
                        row <= last_col ? row + 10'd1 : row;
                        if (last_px) begin
                            bus.pix_ready <= 1'b0;
                            state         <= DONE;
                        end
                    end
                end
                WRITE: if (cnt == CW'(WRITE_CYCLES - 1)) begin
                    bus.sram_we_n <= 1'b1;
                    bus.sram_ce_n <= 1'b1;
                    bus.sram_lb_n <= 1'b1;
                    bus.sram_ub_n <= 1'b1;
                    col           <= last_col ? '0 : col + 10'd1;
                    row           <= last_col ? row + 10'd1 : row;
                    state         <= last_px ? DONE : ACCEPT;
                    bus.pix_ready <= !last_px;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
